// File: rtl/control_sequencer.sv
// control_sequencer
//
// Hardwired control unit for the single-bus datapath. Fetches an instruction
// (T0-T2), decodes the opcode held in IR (T3) and walks the execute steps for
// three-register ALU ops, unary ops and mul/div, then loops back to T0. A halt
// opcode parks the sequencer in HALT until clr.
//
// Ports
//   clk          system clock, rising edge
//   clr          synchronous active-high reset, priority over everything
//   start        leaves RESET and begins fetch (only looked at in RESET)
//   IR           datapath IR: opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15]
//   PCout..Loin  single-bit datapath strobes
//   Rin, Rout    one-hot register load / register bus drive
//   ALU_opcode   operation for the ALU (0 when not driving the ALU)
//   run          high in any T-state
//   instr_count  number of completed instructions, wraps at 16 bits
//
// Outputs are Moore: decoded from the state register and the live IR, because
// IR only becomes valid at the edge into T3.

module control_sequencer #(
    parameter int unsigned NREGS = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [31:0]      IR,
    output logic             PCout,
    output logic             MARin,
    output logic             IncPC,
    output logic             Zin,
    output logic             PCin,
    output logic             Read,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             Yin,
    output logic             ZLOout,
    output logic             ZHIout,
    output logic             HIin,
    output logic             Loin,
    output logic [NREGS-1:0] Rin,
    output logic [NREGS-1:0] Rout,
    output logic [4:0]       ALU_opcode,
    output logic             run,
    output logic [15:0]      instr_count
);

    typedef enum logic [3:0] {
        StReset,
        StT0,
        StT1,
        StT2,
        StT3,
        StT4,
        StT5,
        StT6,
        StHalt
    } state_e;

    typedef enum logic [2:0] {
        ClsNop,
        ClsAlu3,
        ClsMulDiv,
        ClsUnary,
        ClsHalt
    } class_e;

    state_e          state_q;
    logic [15:0]     instr_count_q;
    class_e          op_class;

    logic [4:0]      opcode;
    logic [3:0]      ra;
    logic [3:0]      rb;
    logic [3:0]      rc;
    logic [NREGS-1:0] ra_onehot;
    logic [NREGS-1:0] rb_onehot;
    logic [NREGS-1:0] rc_onehot;

    logic            unused_ir;

    assign opcode = IR[31:27];
    assign ra     = IR[26:23];
    assign rb     = IR[22:19];
    assign rc     = IR[18:15];

    // Low IR bits carry immediates the sequencer does not need.
    assign unused_ir = ^IR[14:0];

    assign ra_onehot = NREGS'(1) << ra;
    assign rb_onehot = NREGS'(1) << rb;
    assign rc_onehot = NREGS'(1) << rc;

    assign instr_count = instr_count_q;

    // Opcode class decode; anything unlisted runs as a nop.
    always_comb begin
        op_class = ClsNop;
        case (opcode)
            5'b00011, 5'b00100, 5'b00101, 5'b00110,
            5'b00111, 5'b01000, 5'b01001, 5'b01010: op_class = ClsAlu3;
            5'b01111, 5'b10000:                     op_class = ClsMulDiv;
            5'b10001, 5'b10010:                     op_class = ClsUnary;
            5'b11011:                               op_class = ClsHalt;
            default:                                op_class = ClsNop;
        endcase
    end

    // State sequencing and the completed-instruction counter. The counter
    // steps only on the return to T0 from the last execute step, so the
    // RESET->T0 entry and HALT entry never count.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q       <= StReset;
            instr_count_q <= '0;
        end else begin
            case (state_q)
                StReset: begin
                    if (start) begin
                        state_q <= StT0;
                    end
                end
                StT0: state_q <= StT1;
                StT1: state_q <= StT2;
                StT2: state_q <= StT3;
                StT3: begin
                    case (op_class)
                        ClsHalt: state_q <= StHalt;
                        ClsNop: begin
                            state_q       <= StT0;
                            instr_count_q <= instr_count_q + 16'd1;
                        end
                        default: state_q <= StT4;
                    endcase
                end
                StT4: begin
                    if (op_class == ClsAlu3 || op_class == ClsMulDiv) begin
                        state_q <= StT5;
                    end else begin
                        state_q       <= StT0;
                        instr_count_q <= instr_count_q + 16'd1;
                    end
                end
                StT5: begin
                    if (op_class == ClsMulDiv) begin
                        state_q <= StT6;
                    end else begin
                        state_q       <= StT0;
                        instr_count_q <= instr_count_q + 16'd1;
                    end
                end
                StT6: begin
                    state_q       <= StT0;
                    instr_count_q <= instr_count_q + 16'd1;
                end
                StHalt:  state_q <= StHalt;
                default: state_q <= StReset;
            endcase
        end
    end

    // Strobe decode from state and IR.
    always_comb begin
        PCout      = 1'b0;
        MARin      = 1'b0;
        IncPC      = 1'b0;
        Zin        = 1'b0;
        PCin       = 1'b0;
        Read       = 1'b0;
        MDRin      = 1'b0;
        MDRout     = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        ZLOout     = 1'b0;
        ZHIout     = 1'b0;
        HIin       = 1'b0;
        Loin       = 1'b0;
        Rin        = '0;
        Rout       = '0;
        ALU_opcode = '0;
        run        = 1'b0;

        case (state_q)
            StT0: begin
                run   = 1'b1;
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            StT1: begin
                run    = 1'b1;
                ZLOout = 1'b1;
                PCin   = 1'b1;
                Read   = 1'b1;
                MDRin  = 1'b1;
            end
            StT2: begin
                run    = 1'b1;
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            StT3: begin
                run = 1'b1;
                case (op_class)
                    ClsAlu3: begin
                        Rout = rb_onehot;
                        Yin  = 1'b1;
                    end
                    ClsMulDiv: begin
                        Rout = ra_onehot;
                        Yin  = 1'b1;
                    end
                    ClsUnary: begin
                        Rout       = rb_onehot;
                        Zin        = 1'b1;
                        ALU_opcode = opcode;
                    end
                    default: ;
                endcase
            end
            StT4: begin
                run = 1'b1;
                case (op_class)
                    ClsAlu3: begin
                        Rout       = rc_onehot;
                        Zin        = 1'b1;
                        ALU_opcode = opcode;
                    end
                    ClsMulDiv: begin
                        Rout       = rb_onehot;
                        Zin        = 1'b1;
                        ALU_opcode = opcode;
                    end
                    ClsUnary: begin
                        ZLOout = 1'b1;
                        Rin    = ra_onehot;
                    end
                    default: ;
                endcase
            end
            StT5: begin
                run = 1'b1;
                case (op_class)
                    ClsAlu3: begin
                        ZLOout = 1'b1;
                        Rin    = ra_onehot;
                    end
                    ClsMulDiv: begin
                        ZLOout = 1'b1;
                        Loin   = 1'b1;
                    end
                    default: ;
                endcase
            end
            StT6: begin
                run = 1'b1;
                if (op_class == ClsMulDiv) begin
                    ZHIout = 1'b1;
                    HIin   = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer: directed table of per-step expectations,
// randomized instruction stream checked against a per-instruction microstep
// model, and hand sequences for halt, mid-instruction clr and counter wrap.

module tb_control_sequencer;

    localparam int NREGS = 16;

    logic             clk = 1'b0;
    logic             clr;
    logic             start;
    logic [31:0]      IR;
    logic             PCout, MARin, IncPC, Zin, PCin, Read, MDRin;
    logic             MDRout, IRin, Yin, ZLOout, ZHIout, HIin, Loin;
    logic [NREGS-1:0] Rin;
    logic [NREGS-1:0] Rout;
    logic [4:0]       ALU_opcode;
    logic             run;
    logic [15:0]      instr_count;

    always #5 clk = ~clk;

    control_sequencer #(.NREGS(NREGS)) dut (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .IR         (IR),
        .PCout      (PCout),
        .MARin      (MARin),
        .IncPC      (IncPC),
        .Zin        (Zin),
        .PCin       (PCin),
        .Read       (Read),
        .MDRin      (MDRin),
        .MDRout     (MDRout),
        .IRin       (IRin),
        .Yin        (Yin),
        .ZLOout     (ZLOout),
        .ZHIout     (ZHIout),
        .HIin       (HIin),
        .Loin       (Loin),
        .Rin        (Rin),
        .Rout       (Rout),
        .ALU_opcode (ALU_opcode),
        .run        (run),
        .instr_count(instr_count)
    );

    // Strobe vector bit positions: PCout is the MSB, Loin the LSB.
    localparam logic [13:0] S_PCOUT  = 14'h2000;
    localparam logic [13:0] S_MARIN  = 14'h1000;
    localparam logic [13:0] S_INCPC  = 14'h0800;
    localparam logic [13:0] S_ZIN    = 14'h0400;
    localparam logic [13:0] S_PCIN   = 14'h0200;
    localparam logic [13:0] S_READ   = 14'h0100;
    localparam logic [13:0] S_MDRIN  = 14'h0080;
    localparam logic [13:0] S_MDROUT = 14'h0040;
    localparam logic [13:0] S_IRIN   = 14'h0020;
    localparam logic [13:0] S_YIN    = 14'h0010;
    localparam logic [13:0] S_ZLOOUT = 14'h0008;
    localparam logic [13:0] S_ZHIOUT = 14'h0004;
    localparam logic [13:0] S_HIIN   = 14'h0002;
    localparam logic [13:0] S_LOIN   = 14'h0001;

    typedef struct packed {
        logic        run;
        logic [4:0]  alu;
        logic [13:0] strb;
        logic [15:0] rin;
        logic [15:0] rout;
    } obs_t;

    typedef struct {
        string       name;
        logic [31:0] ir;
        int          step;
        logic [13:0] strb;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [4:0]  alu;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_cnt;
    obs_t        exp_q[$];
    obs_t        seen[8];
    vec_t        tbl[13];

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'h0};
    endfunction

    function automatic logic [15:0] reg_bit(input logic [3:0] r);
        logic [15:0] one = 16'h0001;
        return one << r;
    endfunction

    function automatic obs_t sample_outs();
        obs_t o;
        o.run  = run;
        o.alu  = ALU_opcode;
        o.strb = {PCout, MARin, IncPC, Zin, PCin, Read, MDRin,
                  MDRout, IRin, Yin, ZLOout, ZHIout, HIin, Loin};
        o.rin  = Rin;
        o.rout = Rout;
        return o;
    endfunction

    task automatic check(input string name, input logic [51:0] act, input logic [51:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Model: the list of per-cycle outputs an instruction should produce from
    // its T0 onward, built from the class rules.
    task automatic build_seq(input logic [31:0] ir_v);
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        obs_t       o;
        op = ir_v[31:27];
        ra = ir_v[26:23];
        rb = ir_v[22:19];
        rc = ir_v[18:15];
        exp_q.delete();
        o = '0; o.run = 1'b1; o.strb = S_PCOUT | S_MARIN | S_INCPC | S_ZIN; exp_q.push_back(o);
        o = '0; o.run = 1'b1; o.strb = S_ZLOOUT | S_PCIN | S_READ | S_MDRIN; exp_q.push_back(o);
        o = '0; o.run = 1'b1; o.strb = S_MDROUT | S_IRIN; exp_q.push_back(o);
        if (op inside {[5'd3:5'd10]}) begin
            o = '0; o.run = 1'b1; o.rout = reg_bit(rb); o.strb = S_YIN; exp_q.push_back(o);
            o = '0; o.run = 1'b1; o.rout = reg_bit(rc); o.strb = S_ZIN; o.alu = op;
            exp_q.push_back(o);
            o = '0; o.run = 1'b1; o.rin = reg_bit(ra); o.strb = S_ZLOOUT; exp_q.push_back(o);
        end else if (op == 5'd15 || op == 5'd16) begin
            o = '0; o.run = 1'b1; o.rout = reg_bit(ra); o.strb = S_YIN; exp_q.push_back(o);
            o = '0; o.run = 1'b1; o.rout = reg_bit(rb); o.strb = S_ZIN; o.alu = op;
            exp_q.push_back(o);
            o = '0; o.run = 1'b1; o.strb = S_ZLOOUT | S_LOIN; exp_q.push_back(o);
            o = '0; o.run = 1'b1; o.strb = S_ZHIOUT | S_HIIN; exp_q.push_back(o);
        end else if (op == 5'd17 || op == 5'd18) begin
            o = '0; o.run = 1'b1; o.rout = reg_bit(rb); o.strb = S_ZIN; o.alu = op;
            exp_q.push_back(o);
            o = '0; o.run = 1'b1; o.rin = reg_bit(ra); o.strb = S_ZLOOUT; exp_q.push_back(o);
        end else begin
            // nop and halt: one silent decode step
            o = '0; o.run = 1'b1; exp_q.push_back(o);
        end
    endtask

    // Entered at a falling edge with the DUT in T0; leaves at the falling
    // edge after the instruction's last step (next T0, or HALT).
    task automatic exec_instr(input logic [31:0] ir_v, input string name);
        bit is_halt;
        is_halt = (ir_v[31:27] == 5'b11011);
        IR = ir_v;
        build_seq(ir_v);
        for (int k = 0; k < exp_q.size(); k++) begin
            seen[k] = sample_outs();
            check($sformatf("%s step %0d", name, k), seen[k], exp_q[k]);
            @(posedge clk);
            @(negedge clk);
        end
        if (!is_halt) exp_cnt = exp_cnt + 16'd1;
        check({name, " count"}, 52'(instr_count), 52'(exp_cnt));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        logic [31:0] ir_add, ir_mul, ir_not, ir_nop, ir_halt, ir_r;
        logic [4:0]  op_r;
        obs_t        e;

        ir_add  = 32'h1A920000;
        ir_mul  = mk_ir(5'b01111, 4'd3, 4'd1, 4'd0);
        ir_not  = mk_ir(5'b10010, 4'd7, 4'd2, 4'd0);
        ir_nop  = mk_ir(5'b11010, 4'd9, 4'd6, 4'd11);
        ir_halt = mk_ir(5'b11011, 4'd0, 4'd0, 4'd0);

        tbl[0]  = '{"fetch T0", ir_add, 0, S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 16'h0, 16'h0, 5'd0};
        tbl[1]  = '{"fetch T1", ir_add, 1, S_ZLOOUT | S_PCIN | S_READ | S_MDRIN, 16'h0, 16'h0, 5'd0};
        tbl[2]  = '{"fetch T2", ir_add, 2, S_MDROUT | S_IRIN, 16'h0, 16'h0, 5'd0};
        tbl[3]  = '{"add T3", ir_add, 3, S_YIN, 16'h0, 16'h0004, 5'd0};
        tbl[4]  = '{"add T4", ir_add, 4, S_ZIN, 16'h0, 16'h0010, 5'b00011};
        tbl[5]  = '{"add T5", ir_add, 5, S_ZLOOUT, 16'h0020, 16'h0, 5'd0};
        tbl[6]  = '{"mul T3", ir_mul, 3, S_YIN, 16'h0, 16'h0008, 5'd0};
        tbl[7]  = '{"mul T4", ir_mul, 4, S_ZIN, 16'h0, 16'h0002, 5'b01111};
        tbl[8]  = '{"mul T5", ir_mul, 5, S_ZLOOUT | S_LOIN, 16'h0, 16'h0, 5'd0};
        tbl[9]  = '{"mul T6", ir_mul, 6, S_ZHIOUT | S_HIIN, 16'h0, 16'h0, 5'd0};
        tbl[10] = '{"not T3", ir_not, 3, S_ZIN, 16'h0, 16'h0004, 5'b10010};
        tbl[11] = '{"not T4", ir_not, 4, S_ZLOOUT, 16'h0080, 16'h0, 5'd0};
        tbl[12] = '{"nop T3", ir_nop, 3, 14'h0, 16'h0, 16'h0, 5'd0};

        clr     = 1'b1;
        start   = 1'b0;
        IR      = '0;
        exp_cnt = '0;
        tick();
        tick();
        check("reset outputs", sample_outs(), '0);
        check("reset count", 52'(instr_count), 52'd0);

        // Without start the sequencer must stay idle.
        clr = 1'b0;
        repeat (3) tick();
        check("idle without start", sample_outs(), '0);

        pulse_start();
        check("no count on start", 52'(instr_count), 52'd0);

        // Directed table; re-run an instruction only when the IR changes.
        for (int i = 0; i < 13; i++) begin
            if (i == 0 || tbl[i].ir != tbl[i-1].ir) exec_instr(tbl[i].ir, tbl[i].name);
            e      = '0;
            e.run  = 1'b1;
            e.strb = tbl[i].strb;
            e.rin  = tbl[i].rin;
            e.rout = tbl[i].rout;
            e.alu  = tbl[i].alu;
            check({"table ", tbl[i].name}, seen[tbl[i].step], e);
        end

        // Random instruction stream, halt excluded.
        for (int i = 0; i < 200; i++) begin
            op_r = 5'($urandom_range(0, 31));
            if (op_r == 5'b11011) op_r = 5'b11010;
            ir_r = $urandom;
            ir_r[31:27] = op_r;
            exec_instr(ir_r, $sformatf("rand%0d", i));
        end

        // Counter wrap: preset near the top instead of running 65535 nops.
        force dut.instr_count_q = 16'hFFFE;
        #1;
        release dut.instr_count_q;
        exp_cnt = 16'hFFFE;
        exec_instr(ir_nop, "wrap nop");
        exec_instr(ir_add, "wrap add");

        // clr during T4 of an add.
        IR = ir_add;
        repeat (4) tick();
        e      = '0;
        e.run  = 1'b1;
        e.strb = S_ZIN;
        e.rout = 16'h0010;
        e.alu  = 5'b00011;
        check("pre-clr T4", sample_outs(), e);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("mid clr outputs", sample_outs(), '0);
        check("mid clr count", 52'(instr_count), 52'd0);
        exp_cnt = '0;
        repeat (3) begin
            tick();
            check("after mid clr idle", sample_outs(), '0);
        end

        pulse_start();
        exec_instr(ir_not, "post clr not");

        // Halt, with start toggled to show it is ignored there.
        exec_instr(ir_halt, "halt");
        for (int i = 0; i < 12; i++) begin
            start = i[0];
            check($sformatf("halt hold %0d", i), sample_outs(), '0);
            tick();
        end
        start = 1'b0;
        check("halt count held", 52'(instr_count), 52'(exp_cnt));

        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("halt clr outputs", sample_outs(), '0);
        check("halt clr count", 52'(instr_count), 52'd0);
        exp_cnt = '0;
        pulse_start();
        exec_instr(ir_mul, "restart mul");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
